// File: rtl/mips_alu_mc.sv
// Multi-cycle MIPS ALU: registered single-cycle ops plus iterative unsigned
// multiply/divide into HI/LO with a start/busy/done handshake.
module mips_alu_mc #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func_field,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLLV, OP_SRLV, OP_SRAV, OP_MFHI, OP_MFLO, OP_MULTU, OP_DIVU
    } alu_op_e;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

    state_e           state;
    alu_op_e          alu_op;
    logic [WIDTH-1:0] alu_res;
    logic [SHW:0]     count;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        alu_op = OP_ADD;
        if (opcode == 6'h00) begin
            case (func_field)
                6'h20:   alu_op = OP_ADD;
                6'h22:   alu_op = OP_SUB;
                6'h24:   alu_op = OP_AND;
                6'h25:   alu_op = OP_OR;
                6'h26:   alu_op = OP_XOR;
                6'h27:   alu_op = OP_NOR;
                6'h2A:   alu_op = OP_SLT;
                6'h2B:   alu_op = OP_SLTU;
                6'h04:   alu_op = OP_SLLV;
                6'h06:   alu_op = OP_SRLV;
                6'h07:   alu_op = OP_SRAV;
                6'h10:   alu_op = OP_MFHI;
                6'h12:   alu_op = OP_MFLO;
                6'h19:   alu_op = OP_MULTU;
                6'h1B:   alu_op = OP_DIVU;
                default: alu_op = OP_ADD;
            endcase
        end else begin
            case (opcode)
                6'h04, 6'h05: alu_op = OP_SUB;
                default:      alu_op = OP_ADD;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLLV: alu_res = B << A[SHW-1:0];
            OP_SRLV: alu_res = B >> A[SHW-1:0];
            OP_SRAV: alu_res = $unsigned($signed(B) >>> A[SHW-1:0]);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // p_hi/p_lo double as product accumulator (MUL) and remainder/dividend (DIV).
    always_comb begin
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, operand} : '0);
        div_shift = {p_hi, p_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (state == S_DIV) begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], p_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            operand <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (alu_op == OP_MULTU) begin
                            operand <= A;
                            p_hi    <= '0;
                            p_lo    <= B;
                            count   <= CNT_INIT;
                            busy    <= 1'b1;
                            state   <= S_MUL;
                        end else if (alu_op == OP_DIVU) begin
                            operand <= B;
                            p_hi    <= '0;
                            p_lo    <= A;
                            count   <= CNT_INIT;
                            busy    <= 1'b1;
                            state   <= S_DIV;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    p_hi  <= step_hi;
                    p_lo  <= step_lo;
                    count <= count - 1'b1;
                    if (count == CNT_LAST) begin
                        hi     <= step_hi;
                        lo     <= step_lo;
                        result <= step_lo;
                        zero   <= (step_lo == '0);
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_alu_mc.sv
// Scoreboard bench for mips_alu_mc: stimulus pushes expected responses,
// a monitor pops and compares them on every done pulse.
module tb_mips_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   opcode;
    logic [5:0]   func_field;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mips_alu_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .func_field (func_field),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .zero       (zero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           cyc;
        logic [W-1:0] res;
        logic         z;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {{(W-1){1'b0}}, done}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_cycle"},  W'(cyc), W'(e.cyc));
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_zero"},   {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, e.z});
                check({e.name, "_hi"},     hi, e.hi);
                check({e.name, "_lo"},     lo, e.lo);
            end
        end
    end

    task automatic op1(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        exp_t e;
        opcode = op; func_field = fn; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.name = name; e.cyc = cyc; e.res = r; e.z = (r == '0);
        e.hi   = m_hi; e.lo = m_lo;
        sb.push_back(e);
    endtask

    task automatic opm(input string name, input logic [5:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input bit inject);
        exp_t e;
        int   nb;
        opcode = 6'h00; func_field = fn; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        m_hi   = hi_e; m_lo = lo_e;
        e.name = name; e.cyc = cyc + W; e.res = lo_e; e.z = (lo_e == '0);
        e.hi   = hi_e; e.lo = lo_e;
        sb.push_back(e);
        nb = 0;
        for (int k = 1; k <= W + 8; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            nb++;
            if (inject && k == 5) begin
                opcode = 6'h00; func_field = 6'h20; A = 'h7; B = 'h9; start = 1'b1;
            end
            if (inject && k == 6) start = 1'b0;
        end
        check({name, "_busy_cycles"}, W'(nb), W'(W));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = '0; func_field = '0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   {{(W-1){1'b0}}, busy}, '0);
        check("rst_done",   {{(W-1){1'b0}}, done}, '0);
        check("rst_result", result, '0);
        check("rst_zero",   {{(W-1){1'b0}}, zero}, 'h1);
        check("rst_hi",     hi, '0);
        check("rst_lo",     lo, '0);
        rst_n = 1'b1;

        op1("add", 6'h00, 6'h20, 'h2222, 'h1111, 'h3333);
        @(negedge clk);
        check("add_busy", {{(W-1){1'b0}}, busy}, '0);

        // back-to-back single-cycle ops
        op1("beq",   6'h04, 6'h00, 'h5555, 'h5555, 'h0);
        op1("badop", 6'h3F, 6'h00, 'h1, 'h2, 'h3);
        op1("slt",   6'h00, 6'h2A, 'hFFFF_FFFF, 'h1, 'h1);
        op1("sltu",  6'h00, 6'h2B, 'hFFFF_FFFF, 'h1, 'h0);
        op1("srav",  6'h00, 6'h07, 'h4, 'h8000_0000, 'hF800_0000);
        op1("sub",   6'h00, 6'h22, 'h5, 'h7, 'hFFFF_FFFE);
        op1("and",   6'h00, 6'h24, 'hF0F0_00FF, 'h0FF0_0F0F, 'h00F0_000F);
        op1("or",    6'h00, 6'h25, 'hF0F0_00FF, 'h0FF0_0F0F, 'hFFF0_0FFF);
        op1("xor",   6'h00, 6'h26, 'hF0F0_00FF, 'h0FF0_0F0F, 'hFF00_0FF0);
        op1("nor",   6'h00, 6'h27, 'hF0F0_00FF, 'h0FF0_0F0F, 'h000F_F000);
        op1("sllv",  6'h00, 6'h04, 'h8, 'h1234_5678, 'h3456_7800);
        op1("srlv",  6'h00, 6'h06, 'd36, 'h8000_0000, 'h0800_0000);
        op1("lw",    6'h23, 6'h00, 'h1000, 'h24, 'h1024);
        op1("bne",   6'h05, 6'h00, 'h3, 'h5, 'hFFFF_FFFE);
        op1("badfn", 6'h00, 6'h3F, 'h1, 'h1, 'h2);
        op1("mfhi0", 6'h00, 6'h10, 'h0, 'h0, 'h0);

        opm("multu", 6'h19, 'h0001_0000, 'h0001_0001, 'h1, 'h0001_0000, 1'b1);
        op1("mfhi",  6'h00, 6'h10, 'h0, 'h0, 'h1);
        op1("mflo",  6'h00, 6'h12, 'h0, 'h0, 'h0001_0000);
        opm("divu",  6'h1B, 'd100, 'd7, 'd2, 'd14, 1'b0);
        op1("mfhi2", 6'h00, 6'h10, 'h0, 'h0, 'h2);
        opm("div0",  6'h1B, 'h1234, 'h0, 'h1234, 'hFFFF_FFFF, 1'b0);

        // reset in the middle of a multiply aborts without touching hi/lo
        opcode = 6'h00; func_field = 6'h19; A = 'h3; B = 'h5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {{(W-1){1'b0}}, busy}, '0);
        check("abort_done",   {{(W-1){1'b0}}, done}, '0);
        check("abort_hi",     hi, '0);
        check("abort_lo",     lo, '0);
        check("abort_result", result, '0);
        check("abort_zero",   {{(W-1){1'b0}}, zero}, 'h1);
        m_hi = '0; m_lo = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        op1("add_after_rst", 6'h00, 6'h20, 'h1, 'h1, 'h2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
